// File: rtl/pipe_ctrl_if.sv
// ID-stage control bundle: decoded-instruction inputs from IF/ID and the
// registered ID/EX control word, hazard and MDU status back to the core.
interface pipe_ctrl_if #(
    parameter int CNT_W = 6
);
    // Handshake: IF/ID offers an instruction with id_valid; stall is the
    // inverse of ready. The instruction is consumed on a rising edge where
    // id_valid=1 and stall=0; while stall=1 the producer holds every id_*
    // field stable. ex_flush overrides both and discards ID/EX plus any
    // in-flight MDU operation on that edge.
    logic             id_valid;
    logic [6:0]       id_op;
    logic [2:0]       id_funct3;
    logic [6:0]       id_funct7;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             ex_flush;
    logic             stall;
    logic             mdu_busy;
    logic             ex_valid;
    logic             ex_RegWrite;
    logic             ex_MemWrite;
    logic             ex_ALUSrc;
    logic [5:0]       ex_EXTOp;
    logic [4:0]       ex_ALUOp;
    logic [2:0]       ex_NPCOp;
    logic [2:0]       ex_DMType;
    logic [1:0]       ex_WDSel;
    logic [4:0]       ex_rd;
    logic [2:0]       ex_mdu_op;
    logic             ex_mdu_start;
    logic             ex_illegal;
    logic [CNT_W-1:0] mdu_cnt;

    modport slave (
        input  id_valid, id_op, id_funct3, id_funct7, id_rs1, id_rs2, id_rd, ex_flush,
        output stall, mdu_busy, ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc,
               ex_EXTOp, ex_ALUOp, ex_NPCOp, ex_DMType, ex_WDSel, ex_rd,
               ex_mdu_op, ex_mdu_start, ex_illegal, mdu_cnt
    );

    modport master (
        output id_valid, id_op, id_funct3, id_funct7, id_rs1, id_rs2, id_rd, ex_flush,
        input  stall, mdu_busy, ex_valid, ex_RegWrite, ex_MemWrite, ex_ALUSrc,
               ex_EXTOp, ex_ALUOp, ex_NPCOp, ex_DMType, ex_WDSel, ex_rd,
               ex_mdu_op, ex_mdu_start, ex_illegal, mdu_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control for the 5-stage RV32I(M) core: decode into the ID/EX
// register, load-use bubbles, EX redirect flushes and MDU occupancy counting.
module pipe_ctrl_unit #(
    parameter bit EN_MEXT    = 1'b1,
    parameter int MDU_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [4:0] ALU_LUI   = 5'b00001;
    localparam logic [4:0] ALU_AUIPC = 5'b00010;
    localparam logic [4:0] ALU_ADD   = 5'b00011;
    localparam logic [4:0] ALU_SUB   = 5'b00100;
    localparam logic [4:0] ALU_BNE   = 5'b00101;
    localparam logic [4:0] ALU_BLT   = 5'b00110;
    localparam logic [4:0] ALU_BGE   = 5'b00111;
    localparam logic [4:0] ALU_BLTU  = 5'b01000;
    localparam logic [4:0] ALU_BGEU  = 5'b01001;
    localparam logic [4:0] ALU_SLT   = 5'b01010;
    localparam logic [4:0] ALU_SLTU  = 5'b01011;
    localparam logic [4:0] ALU_XOR   = 5'b01100;
    localparam logic [4:0] ALU_OR    = 5'b01101;
    localparam logic [4:0] ALU_AND   = 5'b01110;
    localparam logic [4:0] ALU_SLL   = 5'b01111;
    localparam logic [4:0] ALU_SRL   = 5'b10000;
    localparam logic [4:0] ALU_SRA   = 5'b10001;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_JAL  = 3'b010;
    localparam logic [2:0] NPC_JALR = 3'b100;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    // The counter holds the cycles remaining after the first EX cycle;
    // CNT_W must be wide enough that 2**CNT_W > MDU_CYCLES.
    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [2:0] dm_type;
        logic [1:0] wd_sel;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t            dec;
    ctrl_t            ex_q;
    logic             ex_valid_q;
    logic [4:0]       ex_rd_q;
    logic             start_q;
    logic [CNT_W-1:0] cnt_q;

    logic       use_rs1;
    logic       use_rs2;
    logic       is_mop;
    logic       bad;
    logic [4:0] alu_base;
    logic       mdu_busy;
    logic       load_use;

    // funct3 -> ALU op shared by register and immediate arithmetic
    always_comb begin
        alu_base = ALU_ADD;
        case (bus.id_funct3)
            3'b000:  alu_base = ALU_ADD;
            3'b001:  alu_base = ALU_SLL;
            3'b010:  alu_base = ALU_SLT;
            3'b011:  alu_base = ALU_SLTU;
            3'b100:  alu_base = ALU_XOR;
            3'b101:  alu_base = ALU_SRL;
            3'b110:  alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    end

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_mop  = 1'b0;
        bad     = 1'b0;
        case (bus.id_op)
            OP_R: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.reg_write = 1'b1;
                if (bus.id_funct7 == F7_BASE) begin
                    dec.alu_op = alu_base;
                end else if (bus.id_funct7 == F7_ALT && bus.id_funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (bus.id_funct7 == F7_ALT && bus.id_funct3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else if (EN_MEXT && bus.id_funct7 == F7_MEXT) begin
                    is_mop     = 1'b1;
                    dec.mdu_op = bus.id_funct3;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_I: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_I;
                dec.alu_op    = alu_base;
                if (bus.id_funct3 == 3'b001) begin
                    dec.ext_op = EXT_SHAMT;
                    bad        = (bus.id_funct7 != F7_BASE);
                end else if (bus.id_funct3 == 3'b101) begin
                    dec.ext_op = EXT_SHAMT;
                    if (bus.id_funct7 == F7_ALT) dec.alu_op = ALU_SRA;
                    else if (bus.id_funct7 != F7_BASE) bad = 1'b1;
                end
            end
            OP_LOAD: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_I;
                dec.alu_op    = ALU_ADD;
                dec.wd_sel    = WD_MEM;
                case (bus.id_funct3)
                    3'b000:  dec.dm_type = DM_B;
                    3'b001:  dec.dm_type = DM_H;
                    3'b010:  dec.dm_type = DM_W;
                    3'b100:  dec.dm_type = DM_BU;
                    3'b101:  dec.dm_type = DM_HU;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_S;
                dec.alu_op    = ALU_ADD;
                case (bus.id_funct3)
                    3'b000:  dec.dm_type = DM_B;
                    3'b001:  dec.dm_type = DM_H;
                    3'b010:  dec.dm_type = DM_W;
                    default: bad = 1'b1;
                endcase
            end
            OP_BR: begin
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                dec.ext_op = EXT_B;
                dec.npc_op = NPC_BR;
                case (bus.id_funct3)
                    3'b000:  dec.alu_op = ALU_SUB;
                    3'b001:  dec.alu_op = ALU_BNE;
                    3'b100:  dec.alu_op = ALU_BLT;
                    3'b101:  dec.alu_op = ALU_BGE;
                    3'b110:  dec.alu_op = ALU_BLTU;
                    3'b111:  dec.alu_op = ALU_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec.reg_write = 1'b1;
                dec.ext_op    = EXT_J;
                dec.npc_op    = NPC_JAL;
                dec.wd_sel    = WD_PC;
            end
            OP_JALR: begin
                use_rs1       = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_I;
                dec.alu_op    = ALU_ADD;
                dec.npc_op    = NPC_JALR;
                dec.wd_sel    = WD_PC;
                bad           = (bus.id_funct3 != 3'b000);
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_U;
                dec.alu_op    = ALU_LUI;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.ext_op    = EXT_U;
                dec.alu_op    = ALU_AUIPC;
            end
            default: bad = 1'b1;
        endcase
        // Illegal encodings still occupy EX, but with no architectural effect
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            is_mop      = 1'b0;
        end
    end

    assign mdu_busy = (cnt_q != '0);
    assign load_use = ex_valid_q && (ex_q.wd_sel == WD_MEM) && (ex_rd_q != 5'd0) &&
                      ((use_rs1 && bus.id_rs1 == ex_rd_q) || (use_rs2 && bus.id_rs2 == ex_rd_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
        end else if (bus.ex_flush) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
        end else if (mdu_busy) begin
            start_q <= 1'b0;
            cnt_q   <= cnt_q - CNT_W'(1);
        end else if (load_use) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            start_q    <= 1'b0;
        end else begin
            ex_q       <= bus.id_valid ? dec : '0;
            ex_valid_q <= bus.id_valid;
            ex_rd_q    <= bus.id_valid ? bus.id_rd : '0;
            start_q    <= bus.id_valid && is_mop;
            cnt_q      <= (bus.id_valid && is_mop && MDU_CYCLES > 1) ? MDU_LOAD : '0;
        end
    end

    assign bus.stall        = (bus.id_valid && load_use) || mdu_busy;
    assign bus.mdu_busy     = mdu_busy;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_RegWrite  = ex_q.reg_write;
    assign bus.ex_MemWrite  = ex_q.mem_write;
    assign bus.ex_ALUSrc    = ex_q.alu_src;
    assign bus.ex_EXTOp     = ex_q.ext_op;
    assign bus.ex_ALUOp     = ex_q.alu_op;
    assign bus.ex_NPCOp     = ex_q.npc_op;
    assign bus.ex_DMType    = ex_q.dm_type;
    assign bus.ex_WDSel     = ex_q.wd_sel;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_mdu_op    = ex_q.mdu_op;
    assign bus.ex_mdu_start = start_q;
    assign bus.ex_illegal   = ex_q.illegal;
    assign bus.mdu_cnt      = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode table plus hazard, flush,
// MDU occupancy and asynchronous reset sequences on two configurations.
module tb_pipe_ctrl_unit;
    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(6)) bus ();
    pipe_ctrl_if #(.CNT_W(6)) bus_n ();

    pipe_ctrl_unit #(.EN_MEXT(1'b1), .MDU_CYCLES(34), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    pipe_ctrl_unit #(.EN_MEXT(1'b0), .MDU_CYCLES(34), .CNT_W(6)) dut_n (
        .clk(clk), .rst(rst), .bus(bus_n.slave)
    );

    // the no-M configuration sees exactly the same instruction stream
    assign bus_n.id_valid  = bus.id_valid;
    assign bus_n.id_op     = bus.id_op;
    assign bus_n.id_funct3 = bus.id_funct3;
    assign bus_n.id_funct7 = bus.id_funct7;
    assign bus_n.id_rs1    = bus.id_rs1;
    assign bus_n.id_rs2    = bus.id_rs2;
    assign bus_n.id_rd     = bus.id_rd;
    assign bus_n.ex_flush  = bus.ex_flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [28:0] act_w;
    logic [28:0] act_n;
    assign act_w = {bus.ex_valid, bus.ex_RegWrite, bus.ex_MemWrite, bus.ex_ALUSrc, bus.ex_EXTOp,
                    bus.ex_ALUOp, bus.ex_NPCOp, bus.ex_DMType, bus.ex_WDSel, bus.ex_illegal, bus.ex_rd};
    assign act_n = {bus_n.ex_valid, bus_n.ex_RegWrite, bus_n.ex_MemWrite, bus_n.ex_ALUSrc, bus_n.ex_EXTOp,
                    bus_n.ex_ALUOp, bus_n.ex_NPCOp, bus_n.ex_DMType, bus_n.ex_WDSel, bus_n.ex_illegal, bus_n.ex_rd};

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [28:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [28:0] mk(input logic v, input logic rw, input logic mw, input logic as,
                                       input logic [5:0] ext, input logic [4:0] alu, input logic [2:0] npc,
                                       input logic [2:0] dm, input logic [1:0] wd, input logic ill,
                                       input logic [4:0] rd);
        return {v, rw, mw, as, ext, alu, npc, dm, wd, ill, rd};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_valid  = v;
        bus.id_op     = op;
        bus.id_funct3 = f3;
        bus.id_funct7 = f7;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
    endtask

    task automatic idle();
        drive(1'b0, 7'b0010011, 3'b000, 7'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int busy_n;
        int start_n;
        bit found;

        vec[0]  = '{1'b1, 7'b0110011, 3'b000, 7'b0000000, 5'd3,  mk(1,1,0,0,6'b000000,5'b00011,3'b000,3'b000,2'b00,0,5'd3)};
        vec[1]  = '{1'b1, 7'b0000011, 3'b010, 7'b0000000, 5'd5,  mk(1,1,0,1,6'b010000,5'b00011,3'b000,3'b000,2'b01,0,5'd5)};
        vec[2]  = '{1'b1, 7'b0110011, 3'b000, 7'b0100000, 5'd6,  mk(1,1,0,0,6'b000000,5'b00100,3'b000,3'b000,2'b00,0,5'd6)};
        vec[3]  = '{1'b1, 7'b0110011, 3'b101, 7'b0100000, 5'd7,  mk(1,1,0,0,6'b000000,5'b10001,3'b000,3'b000,2'b00,0,5'd7)};
        vec[4]  = '{1'b1, 7'b0010011, 3'b101, 7'b0100000, 5'd8,  mk(1,1,0,1,6'b100000,5'b10001,3'b000,3'b000,2'b00,0,5'd8)};
        vec[5]  = '{1'b1, 7'b0010011, 3'b000, 7'b0000000, 5'd9,  mk(1,1,0,1,6'b010000,5'b00011,3'b000,3'b000,2'b00,0,5'd9)};
        vec[6]  = '{1'b1, 7'b0100011, 3'b010, 7'b0000000, 5'd10, mk(1,0,1,1,6'b001000,5'b00011,3'b000,3'b000,2'b00,0,5'd10)};
        vec[7]  = '{1'b1, 7'b0100011, 3'b000, 7'b0000000, 5'd11, mk(1,0,1,1,6'b001000,5'b00011,3'b000,3'b011,2'b00,0,5'd11)};
        vec[8]  = '{1'b1, 7'b0000011, 3'b100, 7'b0000000, 5'd12, mk(1,1,0,1,6'b010000,5'b00011,3'b000,3'b100,2'b01,0,5'd12)};
        vec[9]  = '{1'b1, 7'b1100011, 3'b000, 7'b0000000, 5'd13, mk(1,0,0,0,6'b000100,5'b00100,3'b001,3'b000,2'b00,0,5'd13)};
        vec[10] = '{1'b1, 7'b1101111, 3'b000, 7'b0000000, 5'd14, mk(1,1,0,0,6'b000001,5'b00000,3'b010,3'b000,2'b10,0,5'd14)};
        vec[11] = '{1'b1, 7'b1100111, 3'b000, 7'b0000000, 5'd15, mk(1,1,0,1,6'b010000,5'b00011,3'b100,3'b000,2'b10,0,5'd15)};
        vec[12] = '{1'b1, 7'b0110111, 3'b000, 7'b0000000, 5'd16, mk(1,1,0,1,6'b000010,5'b00001,3'b000,3'b000,2'b00,0,5'd16)};
        vec[13] = '{1'b1, 7'b1111111, 3'b000, 7'b0000000, 5'd17, mk(1,0,0,0,6'b000000,5'b00000,3'b000,3'b000,2'b00,1,5'd17)};
        vec[14] = '{1'b1, 7'b0110011, 3'b001, 7'b0100000, 5'd18, mk(1,0,0,0,6'b000000,5'b00000,3'b000,3'b000,2'b00,1,5'd18)};
        vec[15] = '{1'b0, 7'b0110011, 3'b000, 7'b0000000, 5'd19, mk(0,0,0,0,6'b000000,5'b00000,3'b000,3'b000,2'b00,0,5'd0)};

        // clock/reset
        rst = 1'b0;
        bus.ex_flush = 1'b0;
        idle();
        #1 rst = 1'b1;
        #1;
        check("reset_ctrl", act_w, 29'd0);
        check("reset_busy", bus.mdu_busy, 0);
        check("reset_stall", bus.stall, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // decode table, both configurations
        for (int i = 0; i < NV; i++) begin
            drive(vec[i].v, vec[i].op, vec[i].f3, vec[i].f7, 5'd1, 5'd2, vec[i].rd);
            @(negedge clk);
            check($sformatf("vec%0d", i), act_w, vec[i].exp);
            check($sformatf("vec%0d_nom", i), act_n, vec[i].exp);
        end

        // add x3,x1,x2 ; lw x5,0(x3): no dependency on a load
        drive(1'b1, 7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        check("add_aluop", bus.ex_ALUOp, 5'b00011);
        drive(1'b1, 7'b0000011, 3'b010, 7'b0, 5'd3, 5'd0, 5'd5);
        #1 check("add_lw_stall", bus.stall, 0);
        @(negedge clk);
        check("lw_word", act_w, mk(1,1,0,1,6'b010000,5'b00011,3'b000,3'b000,2'b01,0,5'd5));

        // lw x5,0(x1) ; add x6,x5,x2: one bubble
        drive(1'b1, 7'b0000011, 3'b010, 7'b0, 5'd1, 5'd0, 5'd5);
        @(negedge clk);
        drive(1'b1, 7'b0110011, 3'b000, 7'b0, 5'd5, 5'd2, 5'd6);
        #1 check("lu_stall", bus.stall, 1);
        @(negedge clk);
        check("lu_bubble_valid", bus.ex_valid, 0);
        check("lu_stall_released", bus.stall, 0);
        @(negedge clk);
        check("lu_add_enters", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd6});

        // same with rd=x0: no hazard
        drive(1'b1, 7'b0000011, 3'b010, 7'b0, 5'd1, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 7'b0110011, 3'b000, 7'b0, 5'd0, 5'd2, 5'd6);
        #1 check("x0_no_stall", bus.stall, 0);
        @(negedge clk);
        check("x0_add_enters", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd6});

        // flush while a load-use hazard is pending
        drive(1'b1, 7'b0000011, 3'b010, 7'b0, 5'd1, 5'd0, 5'd5);
        @(negedge clk);
        drive(1'b1, 7'b0110011, 3'b000, 7'b0, 5'd5, 5'd2, 5'd6);
        bus.ex_flush = 1'b1;
        #1 check("flush_lu_stall", bus.stall, 1);
        @(negedge clk);
        check("flush_lu_bubble", act_w, 29'd0);
        // flush with a loadable instruction in ID still yields a bubble
        @(negedge clk);
        check("flush_beats_load", act_w, 29'd0);
        bus.ex_flush = 1'b0;
        @(negedge clk);
        check("after_flush_add", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd6});

        // mul x4,x1,x2 then div x7,x1,x2 back to back
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd4);
        @(negedge clk);
        check("nom_mul_illegal", act_n, mk(1,0,0,0,6'b0,5'b0,3'b0,3'b0,2'b00,1,5'd4));
        check("mul_word", act_w, mk(1,1,0,0,6'b0,5'b0,3'b0,3'b0,2'b00,0,5'd4));
        check("mul_start", bus.ex_mdu_start, 1);
        check("mul_cnt", bus.mdu_cnt, 33);
        drive(1'b1, 7'b0110011, 3'b100, 7'b0000001, 5'd1, 5'd2, 5'd7);
        #1 check("mul_stall", bus.stall, 1);
        cyc = 1;
        busy_n = 0;
        start_n = 0;
        found = 1'b0;
        while (cyc < 60 && !found) begin
            if (bus.ex_valid && bus.ex_rd == 5'd7) begin
                found = 1'b1;
            end else begin
                if (bus.mdu_busy) busy_n++;
                if (bus.ex_mdu_start) start_n++;
                @(negedge clk);
                cyc++;
            end
        end
        check("div_entered", found, 1);
        check("div_entry_cycle", cyc, 35);
        check("mul_busy_cycles", busy_n, 33);
        check("mul_start_pulses", start_n, 1);
        check("div_restart", {bus.ex_mdu_start, bus.ex_mdu_op, bus.mdu_cnt}, {1'b1, 3'b100, 6'd33});
        idle();
        repeat (5) @(negedge clk);
        check("div_cnt_28", bus.mdu_cnt, 28);
        check("div_hold_start", bus.ex_mdu_start, 0);
        bus.ex_flush = 1'b1;
        @(negedge clk);
        bus.ex_flush = 1'b0;
        check("flush_busy_cnt", {bus.mdu_busy, bus.mdu_cnt}, 0);
        check("flush_busy_bubble", act_w, 29'd0);
        #1 check("flush_busy_stall", bus.stall, 0);

        // asynchronous reset with the counter at 17
        drive(1'b1, 7'b0110011, 3'b000, 7'b0000001, 5'd1, 5'd2, 5'd4);
        @(negedge clk);
        drive(1'b1, 7'b0110011, 3'b000, 7'b0, 5'd1, 5'd2, 5'd9);
        for (int k = 0; k < 40 && bus.mdu_cnt != 6'd17; k++) @(negedge clk);
        check("reach_cnt_17", bus.mdu_cnt, 17);
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", act_w, 29'd0);
        check("arst_busy", {bus.mdu_busy, bus.ex_mdu_start, bus.mdu_cnt}, 0);
        check("arst_stall", bus.stall, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("post_reset_idle", act_w, 29'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
